mac_result_quantizer: RTL and testbench

- Downstream of the MAC accumulator: takes the 2*DATA_WIDTH signed accumulator result and produces a DATA_WIDTH signed sample.
- Applies a programmable arithmetic right shift with round-half-up, then saturates to the output range.
- Two-stage registered pipeline with valid/ready on both sides, so it can sit between the DSP-inferred MAC and a narrow write-back path.

---
 rtl/mac_result_quantizer.sv | 117 +++++++++++
 tb/tb_mac_result_quantizer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_result_quantizer.sv
// mac_result_quantizer: rounds, shifts and saturates a wide MAC accumulator result into a narrow signed sample
//
// Two registered stages with valid/ready on both sides:
//   stage 1 : arithmetic right shift by min(shift, ACC_WIDTH-1) with round-half-up,
//             kept ACC_WIDTH+1 bits wide so the rounding carry can never wrap
//   stage 2 : clip to the signed DATA_WIDTH range and flag clipped samples
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   in_acc/shift valid
//   in_ready   out  stage 1 can accept this cycle
//   in_acc     in   ACC_WIDTH signed accumulator value
//   shift      in   SHIFT_W right-shift amount, sampled with in_acc
//   out_valid  out  out_data/out_sat valid
//   out_ready  in   consumer accepts
//   out_data   out  DATA_WIDTH quantized signed sample
//   out_sat    out  this sample was clipped
//
// Optional build macro MAC_QUANT_SAT_CNT_EN adds:
//   sat_clr    in   synchronous clear of sat_count (wins over a coincident increment)
//   sat_count  out  16-bit saturating count of clipped samples handed downstream
module mac_result_quantizer #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 2 * DATA_WIDTH,
    parameter int SHIFT_W    = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ACC_WIDTH-1:0]  in_acc,
    input  logic [SHIFT_W-1:0]    shift,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
`ifdef MAC_QUANT_SAT_CNT_EN
    input  logic                  sat_clr,
    output logic [15:0]           sat_count,
`endif
    output logic                  out_sat
);

    // One guard bit above the accumulator absorbs the rounding carry.
    localparam int EW = ACC_WIDTH + 1;
    localparam logic signed [EW-1:0] MAX_V = {{(EW - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [EW-1:0] MIN_V = {{(EW - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    logic                   s1_valid_q, s1_valid_d;
    logic signed [EW-1:0]   s1_q, s1_d;
    logic                   out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
    logic                   out_sat_q, out_sat_d;
    logic                   s1_ready, s2_ready, in_fire, s1_adv;
    logic                   too_big, too_small;
    int unsigned            s_eff;
    logic signed [EW-1:0]   round_w, sum_w;

    assign s2_ready  = !out_valid_q || out_ready;
    assign s1_ready  = !s1_valid_q || s2_ready;
    assign in_ready  = s1_ready;
    assign in_fire   = in_valid && s1_ready;
    assign s1_adv    = s1_valid_q && s2_ready;
    assign too_big   = s1_q > MAX_V;
    assign too_small = s1_q < MIN_V;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

    always_comb begin
        s_eff       = (32'(shift) > 32'(ACC_WIDTH - 1)) ? 32'(ACC_WIDTH - 1) : 32'(shift);
        round_w     = (s_eff != 0) ? (EW'(1) << (s_eff - 1)) : '0;
        sum_w       = $signed({in_acc[ACC_WIDTH-1], in_acc}) + round_w;
        s1_d        = in_fire ? (sum_w >>> s_eff) : s1_q;
        // When stage 1 is ready it is either empty or emptying, so its next valid is just in_valid.
        s1_valid_d  = s1_ready ? in_valid : s1_valid_q;
        out_valid_d = s2_ready ? s1_valid_q : out_valid_q;
        out_sat_d   = s1_adv ? (too_big || too_small) : out_sat_q;
        out_data_d  = !s1_adv  ? out_data_q :
                      too_big   ? MAX_V[DATA_WIDTH-1:0] :
                      too_small ? MIN_V[DATA_WIDTH-1:0] : s1_q[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_q        <= s1_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

`ifdef MAC_QUANT_SAT_CNT_EN
    logic [15:0] sat_cnt_q, sat_cnt_d;

    assign sat_count = sat_cnt_q;

    always_comb
        sat_cnt_d = sat_clr ? '0 :
                    (out_valid_q && out_ready && out_sat_q && sat_cnt_q != 16'hFFFF) ? sat_cnt_q + 16'd1 :
                    sat_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sat_cnt_q <= '0;
        else        sat_cnt_q <= sat_cnt_d;
    end
`endif

endmodule

// File: tb/tb_mac_result_quantizer.sv
// tb_mac_result_quantizer: scoreboard bench for mac_result_quantizer (directed plan vectors plus random traffic)
module tb_mac_result_quantizer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_acc = '0;
    logic [4:0]  shift = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_sat;
`ifdef MAC_QUANT_SAT_CNT_EN
    logic        sat_clr = 1'b0;
    logic [15:0] sat_count;
    int          exp_cnt = 0;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [15:0] q_d[$];
    logic        q_s[$];
    logic        hold_v = 1'b0;
    logic [15:0] hold_d = '0;
    logic        hold_s = 1'b0;
    bit          done = 1'b0;

    always #5 clk = ~clk;

    mac_result_quantizer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_acc    (in_acc),
        .shift     (shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef MAC_QUANT_SAT_CNT_EN
        .sat_clr   (sat_clr),
        .sat_count (sat_count),
`endif
        .out_sat   (out_sat)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: exact integer arithmetic, floor((acc + half) / 2^s), then clamp.
    function automatic void model(input logic [31:0] acc, input logic [4:0] sh,
                                  output logic [15:0] d, output logic sat);
        int     s = (sh > 31) ? 31 : int'(sh);
        longint v = longint'($signed(acc));
        if (s > 0) v = v + (longint'(1) << (s - 1));
        v = v >>> s;
        sat = (v > 32767) || (v < -32768);
        d = (v > 32767) ? 16'h7FFF : (v < -32768) ? 16'h8000 : v[15:0];
    endfunction

    // Called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic send_exp(input logic [31:0] acc, input logic [4:0] sh,
                            input logic [15:0] d, input logic s);
        int n = 0;
        in_acc = acc;
        shift = sh;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready still 0 after %0d cycles, expected 1", n);
        end else begin
            q_d.push_back(d);
            q_s.push_back(s);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send(input logic [31:0] acc, input logic [4:0] sh);
        logic [15:0] d;
        logic s;
        model(acc, sh, d, s);
        send_exp(acc, sh, d, s);
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (q_d.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1 chk("drain_left", q_d.size(), 0);
    endtask

    // Monitor: pops the scoreboard on every output handshake and checks hold-during-stall.
    always @(negedge clk) begin
        if (rst_n) begin
`ifdef MAC_QUANT_SAT_CNT_EN
            chk("sat_count", sat_count, exp_cnt);
            if (sat_clr) exp_cnt = 0;
            else if (out_valid && out_ready && out_sat && exp_cnt < 65535) exp_cnt++;
`endif
            if (hold_v) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, hold_d);
                chk("stall_sat", out_sat, hold_s);
            end
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
            hold_s = out_sat;
            if (out_valid && out_ready) begin
                if (q_d.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got data %h with nothing outstanding", out_data);
                end else begin
                    logic [15:0] ed;
                    logic es;
                    ed = q_d.pop_front();
                    es = q_s.pop_front();
                    chk("out_data", out_data, ed);
                    chk("out_sat", out_sat, es);
                end
            end
        end
    end

    initial begin
        logic [31:0] v_acc[8] = '{32'h0001_2340, 32'd24, 32'hFFFF_FFE8, 32'd23,
                                  32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
        logic [4:0]  v_sh[8]  = '{5'd4, 5'd4, 5'd4, 5'd4, 5'd0, 5'd0, 5'd1, 5'd31};
        logic [15:0] v_d[8]   = '{16'h1234, 16'h0002, 16'hFFFF, 16'h0001,
                                  16'h7FFF, 16'h8000, 16'h7FFF, 16'h0001};
        logic        v_s[8]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        int n;

        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_in_ready", in_ready, 1);
`ifdef MAC_QUANT_SAT_CNT_EN
        chk("rst_sat_count", sat_count, 0);
`endif
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b1;

        // Latency: valid appears two cycles after the handshake cycle.
        send_exp(v_acc[0], v_sh[0], v_d[0], v_s[0]);
        @(negedge clk);
        chk("latency_early", out_valid, 0);
        @(negedge clk);
        chk("latency_valid", out_valid, 1);
        @(posedge clk);
        #1;

        for (int i = 1; i < 8; i++) send_exp(v_acc[i], v_sh[i], v_d[i], v_s[i]);
        drain();

        // Backpressure: consumer stalls while 1,2,3,4 (x16) are offered back to back.
        out_ready = 1'b0;
        fork
            for (int k = 1; k <= 4; k++) send(32'(k * 16), 5'd4);
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!out_valid && n < 20);
                for (int c = 0; c < 3; c++) begin
                    if (c != 0) @(negedge clk);
                    chk("bp_in_ready", in_ready, 0);
                    chk("bp_hold_data", out_data, 16'h0001);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
                for (int k = 1; k <= 4; k++) begin
                    @(negedge clk);
                    chk("bp_burst_valid", out_valid, 1);
                    chk("bp_burst_data", out_data, 32'(k));
                end
            end
        join
        drain();

        // Reset mid-stream with both stages full.
        out_ready = 1'b0;
        send(32'h0000_0050, 5'd4);
        send(32'h0000_0060, 5'd4);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        q_d.delete();
        q_s.delete();
        hold_v = 1'b0;
`ifdef MAC_QUANT_SAT_CNT_EN
        exp_cnt = 0;
`endif
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("post_rst_idle", out_valid, 0);
        end
        @(posedge clk);
        #1;

        // Random traffic with random consumer stalls.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    logic [31:0] a;
                    case ($urandom_range(0, 3))
                        0:       a = $urandom;
                        1:       a = 32'($signed(20'($urandom)));
                        2:       a = 32'h7FFF_0000 + 32'($urandom_range(0, 32'h1FFFF));
                        default: a = 32'h8000_0000 + 32'($urandom_range(0, 32'h1FFFF)) - 32'h1_0000;
                    endcase
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(a, 5'($urandom_range(0, 31)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();

`ifdef MAC_QUANT_SAT_CNT_EN
        sat_clr = 1'b1;
        @(posedge clk);
        #1 sat_clr = 1'b0;
        for (int i = 0; i < 3; i++) send(32'h7FFF_FFFF, 5'd0);
        drain();
        chk("sat_count_3", sat_count, 3);
        out_ready = 1'b0;
        send(32'h8000_0000, 5'd0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        @(posedge clk);
        #1 out_ready = 1'b1;
        sat_clr = 1'b1;
        @(posedge clk);
        #1 sat_clr = 1'b0;
        chk("sat_clr_coincide", sat_count, 0);
        for (int i = 0; i < 65540; i++) send(32'h8000_0000, 5'd0);
        drain();
        chk("sat_count_stick", sat_count, 16'hFFFF);
`endif

        chk("scoreboard_empty", q_d.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
